sar_search_ctrl: RTL and testbench
==================================

Name: sar_search_ctrl

Overview:
- Successive-approximation search controller that drives a trial operand into an N-bit magnitude comparator and consumes its lt/gt/eq result.
- Recovers the unknown operand A present on the comparator's other input, deciding one bit per step from MSB to LSB.
- Terminates early on eq.
- Sits beside the comparator in measurement and threshold-search paths; the comparator sees A on one input and this block's trial on the other.

Parameters:
- word_size, 16, operand MSB index; all value ports are word_size+1 bits wide (W = word_size+1).
- SETTLE, 0, extra wait cycles after each trial update before lt/gt/eq are sampled (comparator or analog settling).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a search; honoured only in IDLE.
- abort  in  1  cancel the search in progress; honoured in WAIT/EVAL.
- lt  in  1  comparator result, A < trial.
- gt  in  1  comparator result, A > trial.
- eq  in  1  comparator result, A == trial.
- trial  out  W  registered value driven to the comparator.
- result  out  W  final search value; held until the next accepted start.
- busy  out  1  high while in WAIT or EVAL.
- done  out  1  one-cycle pulse when a search ends, whether found or error.
- err  out  1  set with done when the flags were not exactly one-hot; cleared on the next accepted start.

Behaviour:
- Reset (rst=1 at an edge): trial=0, result=0, busy=0, done=0, err=0, state=IDLE, bit index=W-1, settle counter=0. rst overrides start and abort, and takes effect mid-search.
- States: IDLE, WAIT, EVAL.
- IDLE, start=1:
  - trial <= 1<<(W-1); idx <= W-1; err <= 0; busy <= 1.
  - Next state: WAIT with counter=SETTLE if SETTLE>0, else EVAL.
- WAIT: decrement the counter each cycle; go to EVAL on the cycle after the counter reaches 0. trial is stable throughout.
- EVAL: sample lt/gt/eq on the edge.
  - Exactly one flag high required. Otherwise: result <= 0, err <= 1, done <= 1, busy <= 0, go to IDLE.
  - eq: result <= trial; done pulse; go to IDLE (early termination).
  - lt: clear trial[idx]. gt: keep trial[idx].
  - If idx>0: set trial[idx-1]; idx <= idx-1; return to WAIT/EVAL as above.
  - If idx==0: result <= decided trial; done pulse; go to IDLE.
  - gt at idx==0 is legal and keeps bit 0. For a static A, the final result always equals A.
- Per-step cost: SETTLE+1 cycles. A search with n comparisons (1 ≤ n ≤ W) raises done in the cycle (SETTLE+1)*n edges after the start edge.
- done: high for exactly one cycle; busy falls in that same cycle.
  - start asserted during the done cycle is accepted, since the FSM is already in IDLE.
- start while busy: ignored.
- abort while busy: go to IDLE next edge with busy=0. No done pulse; result and err unchanged; trial retains its last value.
- abort and start in the same IDLE cycle: start wins (abort is ignored in IDLE).
- trial changes only on EVAL edges and on accepted start; it never changes during WAIT.

Test Plan:
- word_size=16, SETTLE=0, A=17'h00000 (lt every step) -> 17 EVAL cycles. trial sequence 0x10000, 0x08000, ... 0x00001. done at start+17, result=0, err=0.
- word_size=16, SETTLE=0, A=17'h10000 -> eq on the first EVAL. done one cycle after start, result=0x10000, busy high for exactly 1 cycle.
- word_size=3, SETTLE=2, A=4'b1011 -> trial sequence 1000, 1100, 1010, 1011. Each trial held 3 cycles. eq at step 4; done at start+12, result=1011.
- word_size=3, SETTLE=0, A=4'b1111 -> gt at every step, including idx 0. result=1111 after 4 steps, err=0.
- Flags forced lt=gt=1 on the second EVAL -> done and err high together, result=0, busy=0. A new start clears err.
- Interruptions, word_size=16:
  - rst asserted mid-search at step 5 -> next cycle all outputs are at reset values.
  - abort at step 5 -> busy=0, no done pulse, previous result retained.
  - start re-asserted in the done cycle -> a new search begins immediately.

Source files
------------

// File: rtl/sar_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sar_search_ctrl
// Purpose  : Successive-approximation search controller. Drives a trial word
//            into an external magnitude comparator and resolves the unknown
//            operand one bit per step, MSB first, with early exit on eq.
// Revision : 1.0 - initial release
// ============================================================================
module sar_search_ctrl #(
    parameter int word_size = 16,
    parameter int SETTLE    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               lt,
    input  logic               gt,
    input  logic               eq,
    output logic [word_size:0] trial,
    output logic [word_size:0] result,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int W  = word_size + 1;
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_EVAL = 2'd2;

    // After every trial update the FSM either settles first or samples directly.
    localparam logic [1:0]    c_step_state = (SETTLE > 0) ? S_WAIT : S_EVAL;
    localparam logic [CW-1:0] c_settle_cnt = CW'(SETTLE);
    localparam logic [IW-1:0] c_msb_idx    = IW'(W - 1);
    localparam logic [W-1:0]  c_msb_trial  = {1'b1, {(W-1){1'b0}}};

    logic [1:0]    r_state;
    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_trial;
    logic [W-1:0]  r_result;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    logic          w_onehot;
    logic [IW-1:0] w_idx_m1;
    logic [W-1:0]  w_decided;
    logic [W-1:0]  w_next_trial;

    // Resolve the current bit from the comparator and prepare the next trial.
    always_comb begin
        w_onehot     = (lt ^ gt ^ eq) & ~(lt & gt & eq);
        w_idx_m1     = r_idx - IW'(1);
        w_decided    = r_trial;
        if (lt) begin
            w_decided[r_idx] = 1'b0;
        end
        w_next_trial = w_decided;
        if (r_idx != '0) begin
            w_next_trial[w_idx_m1] = 1'b1;
        end
    end

    // Search FSM: idle / settle wait / evaluate, with abort and error exits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= c_msb_idx;
            r_cnt    <= '0;
            r_trial  <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_trial <= c_msb_trial;
                        r_idx   <= c_msb_idx;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= c_settle_cnt;
                        r_state <= c_step_state;
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        // Leaving on count 1 makes each step cost SETTLE+1 cycles.
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt <= CW'(1)) begin
                            r_state <= S_EVAL;
                        end
                    end
                end
                S_EVAL: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (!w_onehot) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (eq) begin
                        r_result <= r_trial;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (r_idx == '0) begin
                        r_trial  <= w_decided;
                        r_result <= w_decided;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_trial <= w_next_trial;
                        r_idx   <= w_idx_m1;
                        r_cnt   <= c_settle_cnt;
                        r_state <= c_step_state;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign trial  = r_trial;
    assign result = r_result;
    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sar_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_search_ctrl
// Purpose  : Self-checking bench for sar_search_ctrl: a 17-bit/no-settle
//            instance and a 4-bit/two-cycle-settle instance, each facing a
//            behavioural comparator, checked against a bit-prefix search model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_search_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        start16 = 1'b0, abort16 = 1'b0, bad16 = 1'b0;
    logic [16:0] a16 = '0;
    logic        lt16, gt16, eq16;
    logic [16:0] trial16, result16;
    logic        busy16, done16, err16;

    logic        start3 = 1'b0, abort3 = 1'b0;
    logic [3:0]  a3 = '0;
    logic        lt3, gt3, eq3;
    logic [3:0]  trial3, result3;
    logic        busy3, done3, err3;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] last_res16 = '0;

    always #5 clk = ~clk;

    // Behavioural comparators; bad16 forces an illegal lt+gt pattern.
    assign lt16 = bad16 ? 1'b1 : (a16 < trial16);
    assign gt16 = bad16 ? 1'b1 : (a16 > trial16);
    assign eq16 = bad16 ? 1'b0 : (a16 == trial16);
    assign lt3  = a3 < trial3;
    assign gt3  = a3 > trial3;
    assign eq3  = a3 == trial3;

    sar_search_ctrl #(.word_size(16), .SETTLE(0)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .abort(abort16),
        .lt(lt16), .gt(gt16), .eq(eq16),
        .trial(trial16), .result(result16),
        .busy(busy16), .done(done16), .err(err16)
    );

    sar_search_ctrl #(.word_size(3), .SETTLE(2)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3),
        .lt(lt3), .gt(gt3), .eq(eq3),
        .trial(trial3), .result(result3),
        .busy(busy3), .done(done3), .err(err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Trial presented at 0-based step s: bits of A above position k, plus bit k set.
    function automatic logic [31:0] trial_at(input logic [31:0] a, input int w, input int s);
        int k;
        logic [31:0] mask;
        k = w - 1 - s;
        mask = ~((32'd1 << (k + 1)) - 32'd1);
        return (a & mask) | (32'd1 << k);
    endfunction

    // Comparisons needed: stops once the lowest set bit of A is reached.
    function automatic int steps_for(input logic [31:0] a, input int w);
        int n;
        n = w;
        for (int b = w - 1; b >= 0; b--) if (a[b]) n = w - b;
        return n;
    endfunction

    task automatic set_start(input int inst, input logic v);
        if (inst != 0) start3 = v; else start16 = v;
    endtask

    task automatic get_obs(input int inst, output logic [31:0] t, output logic [31:0] r,
                           output logic b, output logic d, output logic e);
        if (inst != 0) begin
            t = {28'd0, trial3}; r = {28'd0, result3}; b = busy3; d = done3; e = err3;
        end else begin
            t = {15'd0, trial16}; r = {15'd0, result16}; b = busy16; d = done16; e = err16;
        end
    endtask

    // One full search. pre: start already raised in the current (done) cycle.
    // chain: leave start raised in the done cycle for a back-to-back search.
    task automatic search(input int inst, input logic [31:0] a, input bit pre, input bit chain);
        int w, s, n, k;
        bit seen;
        logic [31:0] t, r;
        logic b, d, e;
        w = (inst != 0) ? 4 : 17;
        s = (inst != 0) ? 2 : 0;
        n = steps_for(a, w);
        if (inst != 0) a3 = a[3:0]; else a16 = a[16:0];
        if (!pre) begin
            @(negedge clk);
            set_start(inst, 1'b1);
        end
        @(negedge clk);
        set_start(inst, 1'b0);
        get_obs(inst, t, r, b, d, e);
        chk("busy_after_start", {31'd0, b}, 32'd1);
        chk("err_after_start", {31'd0, e}, 32'd0);
        chk("first_trial", t, trial_at(a, w, 0));
        seen = 1'b0;
        for (k = 1; k <= 200; k++) begin
            @(negedge clk);
            get_obs(inst, t, r, b, d, e);
            if (d) begin
                seen = 1'b1;
                break;
            end
            chk("busy_during", {31'd0, b}, 32'd1);
            chk("trial_step", t, trial_at(a, w, k / (s + 1)));
        end
        if (!seen) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("done_latency", k, (s + 1) * n);
            chk("result", r, a);
            chk("err_clean", {31'd0, e}, 32'd0);
            chk("busy_at_done", {31'd0, b}, 32'd0);
        end
        if (inst == 0) last_res16 = a;
        if (chain) begin
            set_start(inst, 1'b1);
        end else begin
            @(negedge clk);
            get_obs(inst, t, r, b, d, e);
            chk("done_one_cycle", {31'd0, d}, 32'd0);
        end
    endtask

    initial begin
        bit pend;
        bit ch;
        logic [31:0] ra;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_trial16", {15'd0, trial16}, 32'd0);
        chk("rst_result16", {15'd0, result16}, 32'd0);
        chk("rst_flags16", {29'd0, busy16, done16, err16}, 32'd0);
        chk("rst_trial3", {28'd0, trial3}, 32'd0);
        chk("rst_flags3", {29'd0, busy3, done3, err3}, 32'd0);

        // Directed searches
        search(0, 32'h00000, 1'b0, 1'b0);
        search(0, 32'h10000, 1'b0, 1'b0);
        search(0, 32'h1FFFF, 1'b0, 1'b0);
        search(0, 32'h00001, 1'b0, 1'b0);
        search(1, 32'hB, 1'b0, 1'b0);
        search(1, 32'hF, 1'b0, 1'b0);
        search(1, 32'h0, 1'b0, 1'b0);
        search(1, 32'h8, 1'b0, 1'b0);

        // Illegal flags on the second evaluation
        a16 = 17'h01234;
        @(negedge clk); start16 = 1'b1;
        @(negedge clk); start16 = 1'b0;
        @(negedge clk); bad16 = 1'b1;
        @(negedge clk); bad16 = 1'b0;
        chk("errcase_done", {31'd0, done16}, 32'd1);
        chk("errcase_err", {31'd0, err16}, 32'd1);
        chk("errcase_result", {15'd0, result16}, 32'd0);
        chk("errcase_busy", {31'd0, busy16}, 32'd0);
        @(negedge clk);
        chk("errcase_err_held", {31'd0, err16}, 32'd1);
        chk("errcase_done_drop", {31'd0, done16}, 32'd0);
        last_res16 = 32'd0;
        search(0, 32'h0A5A5, 1'b0, 1'b0);

        // Abort at step 5
        a16 = 17'h12341;
        @(negedge clk); start16 = 1'b1;
        @(negedge clk); start16 = 1'b0;
        repeat (4) @(negedge clk);
        abort16 = 1'b1;
        @(negedge clk); abort16 = 1'b0;
        chk("abort_busy", {31'd0, busy16}, 32'd0);
        chk("abort_done", {31'd0, done16}, 32'd0);
        chk("abort_result", {15'd0, result16}, last_res16);
        chk("abort_err", {31'd0, err16}, 32'd0);
        chk("abort_trial", {15'd0, trial16}, trial_at(32'h12341, 17, 4));
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", {30'd0, done16, busy16}, 32'd0);
        end

        // Start accepted in the done cycle
        search(0, 32'h00400, 1'b0, 1'b1);
        search(0, 32'h1C003, 1'b1, 1'b0);

        // Randomized searches with random back-to-back chaining
        pend = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ra = {15'd0, 17'($urandom)};
            ch = 1'($urandom);
            search(0, ra, pend, ch);
            pend = ch;
        end
        search(0, {15'd0, 17'($urandom)}, pend, 1'b0);
        pend = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ra = {28'd0, 4'($urandom)};
            ch = 1'($urandom);
            search(1, ra, pend, ch);
            pend = ch;
        end
        search(1, {28'd0, 4'($urandom)}, pend, 1'b0);

        // Reset mid-search at step 5
        a16 = 17'h0F0F1;
        @(negedge clk); start16 = 1'b1;
        @(negedge clk); start16 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midrst_trial", {15'd0, trial16}, 32'd0);
        chk("midrst_result", {15'd0, result16}, 32'd0);
        chk("midrst_flags", {29'd0, busy16, done16, err16}, 32'd0);
        chk("midrst_result3", {28'd0, result3}, 32'd0);
        @(negedge clk);
        chk("midrst_stays_idle", {30'd0, busy16, done16}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
